// File: rtl/instr_mem_46.sv
// ---------------------------------------------------------------------------
// instr_mem_46 -- instruction memory for the fetch stage
//
// Purpose:
//   Holds the program as 32-bit instruction words. After reset the block sits
//   in LOAD and accepts words through a valid/ready port. Once the final word
//   is taken, or the array is full, it moves to RUN. In RUN it serves the
//   fetch address combinationally with no latency.
//
// Ports:
//   clk_46       in   1    clock, rising edge
//   rst_46       in   1    asynchronous reset, active low
//   mra_i_46     in   32   fetch byte address
//   mrd_i_46     out  32   instruction word for mra_i_46 (combinational)
//   ld_valid_46  in   1    a load word is present
//   ld_data_46   in   32   load word
//   ld_last_46   in   1    the present load word is the final one
//   ld_ready_46  out  1    a load word can be accepted this cycle
//   reload_46    in   1    pulse: discard the program and return to LOAD
//   run_46       out  1    program loaded, fetches are served
//   words_46     out  W+1  number of loaded words, W = log2(DEPTH_WORDS)
//   err_46       out  1    sticky flag: a bad fetch was seen in RUN
// ---------------------------------------------------------------------------
module instr_mem_46 #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic                           clk_46,
    input  logic                           rst_46,
    input  logic [31:0]                    mra_i_46,
    output logic [31:0]                    mrd_i_46,
    input  logic                           ld_valid_46,
    input  logic [31:0]                    ld_data_46,
    input  logic                           ld_last_46,
    output logic                           ld_ready_46,
    input  logic                           reload_46,
    output logic                           run_46,
    output logic [$clog2(DEPTH_WORDS):0]   words_46,
    output logic                           err_46
);

    localparam int W = $clog2(DEPTH_WORDS);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   ld_ptr;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           accept;
    logic           full_word;
    logic [W-1:0]   idx;
    logic           fetch_good;

    // A load word is taken only in LOAD; a same-cycle reload drops it.
    assign accept    = (state == LOAD) && ld_valid_46 && !reload_46;
    assign full_word = (ld_ptr == W'(DEPTH_WORDS - 1));

    // A fetch is good when it is word aligned, lies inside the array
    // address range and points at a word that has actually been loaded.
    assign idx        = mra_i_46[W+1:2];
    assign fetch_good = (mra_i_46[1:0] == 2'b00)
                     && (mra_i_46[31:W+2] == '0)
                     && ({1'b0, idx} < words_46);

    // Load/run control. Every output here is registered so that run_46 and
    // ld_ready_46 always move together with the state.
    always_ff @(posedge clk_46 or negedge rst_46) begin
        if (!rst_46) begin
            state       <= LOAD;
            ld_ptr      <= '0;
            words_46    <= '0;
            run_46      <= 1'b0;
            ld_ready_46 <= 1'b1;
            err_46      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (reload_46) begin
                        ld_ptr   <= '0;
                        words_46 <= '0;
                    end else if (accept) begin
                        ld_ptr   <= ld_ptr + 1'b1;
                        words_46 <= {1'b0, ld_ptr} + 1'b1;
                        // A full array ends loading even without ld_last_46,
                        // so the pointer never wraps onto loaded words.
                        if (ld_last_46 || full_word) begin
                            state       <= RUN;
                            run_46      <= 1'b1;
                            ld_ready_46 <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (reload_46) begin
                        state       <= LOAD;
                        ld_ptr      <= '0;
                        words_46    <= '0;
                        run_46      <= 1'b0;
                        ld_ready_46 <= 1'b1;
                        err_46      <= 1'b0;
                    end else if (!fetch_good) begin
                        err_46 <= 1'b1;
                    end
                end
                default: begin
                    state       <= LOAD;
                    run_46      <= 1'b0;
                    ld_ready_46 <= 1'b1;
                end
            endcase
        end
    end

    // Storage array. Contents survive reset; words_46 returning to zero is
    // what makes stale words unreachable.
    always_ff @(posedge clk_46) begin
        if (accept) begin
            mem[ld_ptr] <= ld_data_46;
        end
    end

    // Zero-latency fetch path. Anything not served returns the NOP word,
    // including every fetch while a program is being loaded.
    always_comb begin
        mrd_i_46 = NOP_WORD;
        if (state == RUN && fetch_good) begin
            mrd_i_46 = mem[idx];
        end
    end

endmodule

// File: tb/tb_instr_mem_46.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_46 -- self-checking bench for instr_mem_46
//
// Drives directed and random load/fetch/reload traffic. A reference model
// holds the program as a plain array plus a word count and run/error flags,
// and predicts every output once per cycle.
// ---------------------------------------------------------------------------
module tb_instr_mem_46;

    localparam int DEPTH = 256;

    logic        clk_46;
    logic        rst_46;
    logic [31:0] mra_i_46;
    logic [31:0] mrd_i_46;
    logic        ld_valid_46;
    logic [31:0] ld_data_46;
    logic        ld_last_46;
    logic        ld_ready_46;
    logic        reload_46;
    logic        run_46;
    logic [8:0]  words_46;
    logic        err_46;

    instr_mem_46 #(.DEPTH_WORDS(DEPTH), .NOP_WORD(32'h0)) dut (
        .clk_46      (clk_46),
        .rst_46      (rst_46),
        .mra_i_46    (mra_i_46),
        .mrd_i_46    (mrd_i_46),
        .ld_valid_46 (ld_valid_46),
        .ld_data_46  (ld_data_46),
        .ld_last_46  (ld_last_46),
        .ld_ready_46 (ld_ready_46),
        .reload_46   (reload_46),
        .run_46      (run_46),
        .words_46    (words_46),
        .err_46      (err_46)
    );

    initial clk_46 = 1'b0;
    always #5 clk_46 = ~clk_46;

    // Reference model state
    logic [31:0] model_mem [DEPTH];
    int          model_count;
    bit          model_run;
    bit          model_err;

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit modelGood(input logic [31:0] addr);
        return (addr % 4 == 0) && ((addr / 4) < model_count);
    endfunction

    task automatic modelReset();
        model_count = 0;
        model_run   = 0;
        model_err   = 0;
    endtask

    // Called from the negedge: drive inputs, check all outputs against the
    // model, cross the posedge, then advance the model with the same inputs.
    task automatic applyStimulus(input bit valid, input logic [31:0] data,
                                 input bit last, input bit reload,
                                 input logic [31:0] addr);
        logic [31:0] exp_rd;
        ld_valid_46 = valid;
        ld_data_46  = data;
        ld_last_46  = last;
        reload_46   = reload;
        mra_i_46    = addr;
        #1;
        exp_rd = (model_run && modelGood(addr)) ? model_mem[addr / 4] : 32'h0;
        checkOutput("mrd",   mrd_i_46,            exp_rd);
        checkOutput("run",   {31'b0, run_46},     {31'b0, model_run});
        checkOutput("ready", {31'b0, ld_ready_46}, {31'b0, !model_run});
        checkOutput("words", {23'b0, words_46},   model_count);
        checkOutput("err",   {31'b0, err_46},     {31'b0, model_err});
        @(posedge clk_46);
        if (!model_run) begin
            if (reload) begin
                model_count = 0;
            end else if (valid) begin
                model_mem[model_count] = data;
                model_count++;
                if (last || model_count == DEPTH) model_run = 1;
            end
        end else begin
            if (reload) begin
                model_run   = 0;
                model_count = 0;
                model_err   = 0;
            end else if (!modelGood(addr)) begin
                model_err = 1;
            end
        end
        @(negedge clk_46);
    endtask

    task automatic doReset();
        rst_46      = 1'b0;
        ld_valid_46 = 1'b0;
        ld_last_46  = 1'b0;
        reload_46   = 1'b0;
        modelReset();
        repeat (2) @(negedge clk_46);
        rst_46 = 1'b1;
    endtask

    task automatic idle(input logic [31:0] addr);
        applyStimulus(0, 32'h0, 0, 0, addr);
    endtask

    initial begin
        logic [31:0] a_word;
        logic [31:0] addr;
        rst_46      = 1'b0;
        mra_i_46    = '0;
        ld_valid_46 = 1'b0;
        ld_data_46  = '0;
        ld_last_46  = 1'b0;
        reload_46   = 1'b0;
        modelReset();
        @(negedge clk_46);
        doReset();

        // Reset state, then a four-word program with the last flag on word 3
        idle(32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, $urandom, (i == 3), 0, 32'h0);
        end
        idle(32'h0);
        for (int i = 0; i < 4; i++) idle(32'(i * 4));
        idle(32'd16);
        idle(32'd0);
        doReset();

        // Misaligned fetch in RUN
        for (int i = 0; i < 4; i++) applyStimulus(1, $urandom, (i == 3), 0, 32'h0);
        idle(32'd6);
        idle(32'd4);

        // Random traffic with occasional reloads and random program lengths
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) addr = $urandom;
            else addr = 32'($urandom_range(4 * (model_count + 2)));
            if ($urandom_range(1) == 0) addr = addr & 32'hFFFF_FFFC;
            a_word = $urandom;
            applyStimulus($urandom_range(1) == 1, a_word, $urandom_range(7) == 0,
                          $urandom_range(31) == 0, addr);
        end

        // Full array without a last flag; the following word is ignored
        applyStimulus(0, 32'h0, 0, 1, 32'h0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, $urandom, 0, 0, 32'h0);
        applyStimulus(1, 32'hDEAD_BEEF, 1, 0, 32'(4 * (DEPTH - 1)));
        idle(32'(4 * DEPTH));
        idle(32'h0);

        // Reset in the middle of a load, then a one-word program and a reload
        doReset();
        applyStimulus(1, $urandom, 0, 0, 32'h0);
        applyStimulus(1, $urandom, 0, 0, 32'h0);
        doReset();
        idle(32'h0);
        applyStimulus(1, 32'hB0B0_0001, 1, 0, 32'h0);
        idle(32'h0);
        idle(32'd4);
        applyStimulus(0, 32'h0, 0, 1, 32'h0);
        idle(32'h0);
        idle(32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
